ysyx_220053_if_id_queue: RTL and testbench
==========================================

YSYX_220053_IF_ID_QUEUE -- requirements
Module: ysyx_220053_if_id_queue

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning PC width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning entry count; legal values are powers of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  fetch stage presents a valid {pc, instr}.
REQ-006 SHALL have port in_ready  output  1  queue accepts an entry this cycle; fetch stage holds its PC (block) when low.
REQ-007 SHALL have port in_pc  input  XLEN  PC of the fetched instruction.
REQ-008 SHALL have port in_instr  input  32  fetched instruction word.
REQ-009 SHALL have port out_valid  output  1  head entry valid for decode.
REQ-010 SHALL have port out_ready  input  1  decode consumes the head this cycle.
REQ-011 SHALL have port out_pc  output  XLEN  PC of the head entry.
REQ-012 SHALL have port out_instr  output  32  instruction of the head entry.
REQ-013 SHALL have port flush  input  1  redirect (taken branch/jump); discards all entries.
REQ-014 SHALL have port count  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 Enqueue SHALL occur on an edge where in_valid && in_ready && !flush.
REQ-016 Dequeue SHALL occur on an edge where out_valid && out_ready && !flush.
REQ-017 in_ready SHALL equal (count != DEPTH), combinational from state only; no dependence on out_ready.
REQ-018 out_valid SHALL equal (count != 0); out_pc/out_instr SHALL be the oldest entry, driven from registers (no combinational path from in_* to out_*).
REQ-019 Enqueue-to-visible latency SHALL be one cycle: an entry written on edge N is presented at out_* after edge N.
REQ-020 Simultaneous enqueue and dequeue SHALL leave count unchanged and preserve FIFO order.
REQ-021 Read and write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL be derived from count, not pointer equality.
REQ-022 flush SHALL have priority over enqueue and dequeue: on the edge where flush=1, count, rd_ptr and wr_ptr SHALL become 0 and the same-cycle input SHALL be dropped.
REQ-023 After a flush edge, out_valid SHALL be 0 and in_ready SHALL be 1 in the following cycle.
REQ-024 out_pc/out_instr while out_valid=0 are don't-care; the bench SHALL NOT check them.
REQ-025 Entry storage SHALL not require reset; only pointers and count SHALL be reset.
REQ-026 in_valid with in_ready=0 SHALL cause no state change; the producer holds its data.

Reset
REQ-027 While rst=0, count=0, rd_ptr=0, wr_ptr=0 asynchronously; hence out_valid=0, in_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately without waiting for a clock edge.
REQ-029 First enqueue SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-030 Package ysyx_220053_pkg SHALL hold XLEN (64), ILEN (32), IQ_DEPTH (4) and the reset PC constant 64'h80000000.
REQ-031 Storage SHALL be one sub-module ysyx_220053_iq_mem: DEPTH x (XLEN+32) register array, one write port, one asynchronous read port; pointer/count control stays in the top.
REQ-032 The design SHALL contain no DPI calls.

Verification
REQ-033 Reset then in_pc=0x80000000, in_instr=0x00000413 for one cycle, out_ready=0 -> next cycle out_valid=1, out_pc=0x80000000, out_instr=0x00000413, count=1.
REQ-034 Four enqueues (PCs 0x80000000..0x8000000C), out_ready=0 -> count=4, in_ready=0; a fifth in_valid is ignored; then out_ready=1 drains in PC order over four cycles.
REQ-035 count=2, in_valid=1 and out_ready=1 every cycle for 10 cycles -> count stays 2, output PCs strictly ascending by 4, pointers wrap past DEPTH without loss.
REQ-036 count=3 with in_valid=1, out_ready=1, flush=1 on one edge -> next cycle count=0, out_valid=0, in_ready=1; dropped PC never appears at out_pc.
REQ-037 count=3, rst pulsed low between edges -> out_valid falls before the next edge; after release, first enqueue at 0x80000000 appears with count=1.
REQ-038 Random in_valid/out_ready/flush (flush rate 5%) for 10k cycles vs. a scoreboard model -> zero ordering, loss or duplication mismatches.

Source files
------------

// File: rtl/ysyx_220053_pkg.sv
// Shared constants and payload types for the ysyx_220053 core front end.
package ysyx_220053_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned ILEN     = 32;
    localparam int unsigned IQ_DEPTH = 4;

    localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

    // One fetch-to-decode queue entry at the default widths.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } iq_entry_t;

endpackage

// File: rtl/ysyx_220053_iq_mem.sv
// Register-array storage for the IF/ID queue: one write port, one async read port.
module ysyx_220053_iq_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Payload needs no reset; validity is tracked by the owner's count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ysyx_220053_if_id_queue.sv
// Fetch-to-decode instruction queue with flush; head is presented from storage registers.
module ysyx_220053_if_id_queue
    import ysyx_220053_pkg::*;
#(
    parameter int unsigned XLEN  = ysyx_220053_pkg::XLEN,
    parameter int unsigned DEPTH = ysyx_220053_pkg::IQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [ILEN-1:0]            in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [ILEN-1:0]            out_instr,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = XLEN + ILEN;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          do_enq;
    logic          do_deq;
    logic [EW-1:0] rd_data;

    // Full/empty come only from the count register, never from out_ready.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != CW'(0));
    assign count     = count_q;

    assign do_enq = in_valid && in_ready && !flush;
    assign do_deq = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    ysyx_220053_iq_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_enq),
        .wr_addr (wr_ptr),
        .wr_data ({in_pc, in_instr}),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign out_pc    = rd_data[EW-1:ILEN];
    assign out_instr = rd_data[ILEN-1:0];

endmodule

// File: tb/tb_ysyx_220053_if_id_queue.sv
// Directed and scoreboard-checked stimulus for the IF/ID instruction queue.
module tb_ysyx_220053_if_id_queue;
    import ysyx_220053_pkg::*;

    localparam int unsigned DEPTH = IQ_DEPTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        flush;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_220053_if_id_queue #(
        .XLEN  (64),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .flush     (flush),
        .count     (count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
    endtask

    iq_entry_t   sb[$];
    int unsigned seq;
    logic        enq;
    logic        deq;

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_pc = '0; in_instr = '0;
        #12;
        check("rst_count", 64'(count), 64'd0);
        check("rst_ovalid", 64'(out_valid), 64'd0);
        check("rst_iready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single enqueue visible one cycle later
        push(RESET_PC, 32'h0000_0413);
        check("one_ovalid", 64'(out_valid), 64'd1);
        check("one_pc", out_pc, 64'h8000_0000);
        check("one_instr", 64'(out_instr), 64'h413);
        check("one_count", 64'(count), 64'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("one_drain", 64'(count), 64'd0);

        // Fill to full, fifth offer ignored, then drain in order
        for (int i = 0; i < 4; i++) push(64'h8000_0000 + 64'(i) * 4, 32'(i));
        check("full_count", 64'(count), 64'd4);
        check("full_iready", 64'(in_ready), 64'd0);
        push(64'h8000_0010, 32'hdead_beef);
        check("full_hold_count", 64'(count), 64'd4);
        check("full_hold_pc", out_pc, 64'h8000_0000);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", out_pc, 64'h8000_0000 + 64'(i) * 4);
            check("drain_instr", 64'(out_instr), 64'(i));
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", 64'(out_valid), 64'd0);

        // Streaming at count=2 across pointer wrap
        push(64'h1000, 32'h1);
        push(64'h1004, 32'h2);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_pc = 64'h1008 + 64'(k) * 4;
            in_instr = 32'(k + 3);
            check("stream_pc", out_pc, 64'h1000 + 64'(k) * 4);
            check("stream_count", 64'(count), 64'd2);
            tick();
        end
        in_valid = 1'b0;
        check("stream_tail_pc", out_pc, 64'h1028);
        tick(); tick();
        out_ready = 1'b0;
        check("stream_empty", 64'(count), 64'd0);

        // Flush beats simultaneous enqueue and dequeue
        for (int i = 0; i < 3; i++) push(64'h2000 + 64'(i) * 4, 32'(i));
        in_valid = 1'b1; in_pc = 64'h200c; in_instr = 32'h55; out_ready = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_ovalid", 64'(out_valid), 64'd0);
        check("flush_iready", 64'(in_ready), 64'd1);
        push(64'h3000, 32'h77);
        check("flush_next_pc", out_pc, 64'h3000);
        check("flush_next_count", 64'(count), 64'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) push(64'h4000 + 64'(i) * 4, 32'(i));
        check("pre_rst_count", 64'(count), 64'd3);
        #1 rst = 1'b0;
        #1;
        check("async_ovalid", 64'(out_valid), 64'd0);
        check("async_count", 64'(count), 64'd0);
        check("async_iready", 64'(in_ready), 64'd1);
        #1 rst = 1'b1;
        push(RESET_PC, 32'h0000_0413);
        check("post_rst_pc", out_pc, 64'h8000_0000);
        check("post_rst_count", 64'(count), 64'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("post_rst_drain", 64'(count), 64'd0);

        // Random traffic against a queue model
        seq = 0;
        for (int c = 0; c < 10000; c++) begin
            check("rnd_count", 64'(count), 64'(sb.size()));
            check("rnd_ovalid", 64'(out_valid), 64'(sb.size() != 0));
            check("rnd_iready", 64'(in_ready), 64'(sb.size() != DEPTH));
            if (sb.size() != 0) begin
                check("rnd_pc", out_pc, sb[0].pc);
                check("rnd_instr", 64'(out_instr), 64'(sb[0].instr));
            end
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 99) < 5);
            in_pc     = 64'h8000_0000 + 64'(seq) * 4;
            in_instr  = $urandom;
            enq = in_valid && (sb.size() != DEPTH) && !flush;
            deq = out_ready && (sb.size() != 0) && !flush;
            tick();
            if (flush) begin
                sb.delete();
            end else begin
                if (deq) void'(sb.pop_front());
                if (enq) begin
                    sb.push_back('{pc: in_pc, instr: in_instr});
                    seq++;
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
